clock_time_counter: RTL
=======================

Name: clock_time_counter

Overview:
- BCD time-of-day counter for the clock. Generates a 1 Hz tick from the system clock and keeps hours, minutes and seconds as six BCD digits.
- Each digit output drives one BCD-to-7-segment decoder directly.
- A set mode freezes the time and lets the user step minutes and hours.

Parameters:
- TICK_DIV, 50000000, system-clock cycles per second. Must be >= 2. Prescaler width is clog2(TICK_DIV).

Ports:
- clk_i  in  1  system clock, rising edge
- rst_i  in  1  asynchronous active-high reset
- set_i  in  1  level, 1 = set mode (time frozen)
- inc_min_i  in  1  single-cycle pulse, already debounced; steps minutes in set mode
- inc_hour_i  in  1  single-cycle pulse, already debounced; steps hours in set mode
- sec_unit_o  out  4  BCD seconds units, 0-9
- sec_ten_o  out  4  BCD seconds tens, 0-5
- min_unit_o  out  4  BCD minutes units, 0-9
- min_ten_o  out  4  BCD minutes tens, 0-5
- hour_unit_o  out  4  BCD hours units, 0-9 (0-3 when hour_ten_o = 2)
- hour_ten_o  out  4  BCD hours tens, 0-2
- tick_1hz_o  out  1  one-cycle pulse, high in the first cycle a new second is displayed

Behaviour:
- Reset, asynchronous, while rst_i = 1:
  - all digit outputs 0 (00:00:00)
  - prescaler 0
  - tick_1hz_o 0
- All outputs are registered. No combinational path from any input to any output.
- Run mode (set_i = 0), prescaler counts 0..TICK_DIV-1:
  - On the edge where prescaler = TICK_DIV-1, the prescaler returns to 0, the time advances one second, and tick_1hz_o <= 1.
  - On every other edge tick_1hz_o <= 0.
  - First advance after reset release: on the TICK_DIV-th rising edge, so 00:00:01 and tick are visible from that edge.
- Second increment chain (all in the same edge):
  - sec_unit 9 -> 0 with carry to sec_ten
  - sec_ten 5 with carry -> 0 with carry to min_unit
  - Minutes use the same rule as seconds; minute carry goes to hours.
  - Hours: if hour_ten = 2 and hour_unit = 3, both -> 0 (day wrap). Else hour_unit 9 -> 0 with carry to hour_ten.
  - 23:59:59 -> 00:00:00 in one edge.
- In run mode, inc_min_i and inc_hour_i are ignored.
- Set mode (set_i = 1):
  - Prescaler is held at 0, seconds digits are forced to 00, and tick_1hz_o is 0.
  - inc_min_i = 1: minutes +1 modulo 60 (59 -> 00), no carry into hours.
  - inc_hour_i = 1: hours +1 modulo 24 (23 -> 00).
  - Both high in the same cycle: both apply independently in that edge.
  - Pulses are edge-counted per cycle asserted. A pulse held N cycles steps N times; upstream guarantees single-cycle pulses.
- Set to run transition (set_i 1 -> 0): counting resumes from prescaler 0, so the first second advances TICK_DIV edges after the first cycle with set_i = 0.
- Entering set mode mid-second: the partial prescaler count is discarded. No tick is issued and no pending carry is applied.
- Invariant: no digit output ever holds a value outside its legal range listed under Ports, including just after reset and on any set/inc sequence.
- Reset asserted mid-operation: immediate return to 00:00:00 regardless of set_i or pending pulses.

Test Plan (TICK_DIV = 4):
- Release reset, set_i = 0, run 12 edges -> outputs 00:00:03; tick_1hz_o high exactly on edges 4, 8 and 12, low on all others.
- Preload 23:59:58 via set mode (23 hour steps, 59 minute steps; seconds forced to 00 in set mode), then run to 23:59:58 -> after 4 more edges 23:59:59, after 4 more 00:00:00 with tick high.
- Run to 00:00:59, then set_i = 1 -> seconds 00 next edge, tick stays 0. One inc_min_i pulse -> 00:01:00. Minute 59 plus one pulse -> 00:00:00, hours unchanged.
- Set mode, hours 23, inc_hour_i and inc_min_i pulsed in the same cycle with minutes 05 -> 00:06:00.
- Run mode, inc_min_i and inc_hour_i pulsed 10 times -> no change to minutes or hours; seconds advance only on prescaler wraps.
- Assert rst_i asynchronously between clock edges while at 12:34:56 -> outputs read 00:00:00 before the next edge. After release, first tick arrives on the 4th edge.

Source files
------------

// File: rtl/clock_time_counter.sv
// BCD time-of-day counter: 1 Hz prescaler plus HH:MM:SS digits,
// with a set mode that freezes time and steps minutes and hours.
module clock_time_counter #(
    parameter int unsigned TICK_DIV = 50000000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       set_i,
    input  logic       inc_min_i,
    input  logic       inc_hour_i,
    output logic [3:0] sec_unit_o,
    output logic [3:0] sec_ten_o,
    output logic [3:0] min_unit_o,
    output logic [3:0] min_ten_o,
    output logic [3:0] hour_unit_o,
    output logic [3:0] hour_ten_o,
    output logic       tick_1hz_o
);

    localparam int unsigned PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

    logic [PW-1:0] presc, presc_nx;
    logic          tick_nx;
    logic [3:0]    su_nx, st_nx, mu_nx, mt_nx, hu_nx, ht_nx;
    logic          wrap;
    logic          sec_c, min_c, hr_c;

    // Returns {carry, ten, unit} for a 00..59 field.
    function automatic logic [8:0] inc60(input logic [3:0] t,
                                         input logic [3:0] u);
        logic [3:0] nt, nu;
        logic       c;
        nt = t;
        nu = u + 4'd1;
        c  = 1'b0;
        if (u == 4'd9) begin
            nu = 4'd0;
            if (t == 4'd5) begin
                nt = 4'd0;
                c  = 1'b1;
            end else begin
                nt = t + 4'd1;
            end
        end
        return {c, nt, nu};
    endfunction

    // Returns {carry, ten, unit} for a 00..23 field.
    function automatic logic [8:0] inc24(input logic [3:0] t,
                                         input logic [3:0] u);
        logic [3:0] nt, nu;
        logic       c;
        nt = t;
        nu = u + 4'd1;
        c  = 1'b0;
        if (t == 4'd2 && u == 4'd3) begin
            nt = 4'd0;
            nu = 4'd0;
            c  = 1'b1;
        end else if (u == 4'd9) begin
            nu = 4'd0;
            nt = t + 4'd1;
        end
        return {c, nt, nu};
    endfunction

    assign wrap = (presc == PMAX);

    always_comb begin
        presc_nx = wrap ? '0 : presc + 1'b1;
        tick_nx  = 1'b0;
        su_nx    = sec_unit_o;
        st_nx    = sec_ten_o;
        mu_nx    = min_unit_o;
        mt_nx    = min_ten_o;
        hu_nx    = hour_unit_o;
        ht_nx    = hour_ten_o;
        sec_c    = 1'b0;
        min_c    = 1'b0;
        hr_c     = 1'b0;
        if (set_i) begin
            presc_nx = '0;
            su_nx    = 4'd0;
            st_nx    = 4'd0;
            if (inc_min_i)
                {min_c, mt_nx, mu_nx} = inc60(min_ten_o, min_unit_o);
            if (inc_hour_i)
                {hr_c, ht_nx, hu_nx} = inc24(hour_ten_o, hour_unit_o);
        end else if (wrap) begin
            tick_nx = 1'b1;
            {sec_c, st_nx, su_nx} = inc60(sec_ten_o, sec_unit_o);
            if (sec_c)
                {min_c, mt_nx, mu_nx} = inc60(min_ten_o, min_unit_o);
            if (sec_c && min_c)
                {hr_c, ht_nx, hu_nx} = inc24(hour_ten_o, hour_unit_o);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            presc       <= '0;
            tick_1hz_o  <= 1'b0;
            sec_unit_o  <= 4'd0;
            sec_ten_o   <= 4'd0;
            min_unit_o  <= 4'd0;
            min_ten_o   <= 4'd0;
            hour_unit_o <= 4'd0;
            hour_ten_o  <= 4'd0;
        end else begin
            presc       <= presc_nx;
            tick_1hz_o  <= tick_nx;
            sec_unit_o  <= su_nx;
            sec_ten_o   <= st_nx;
            min_unit_o  <= mu_nx;
            min_ten_o   <= mt_nx;
            hour_unit_o <= hu_nx;
            hour_ten_o  <= ht_nx;
        end
    end

endmodule
